// File: rtl/apb_reg_pkg.sv
// Shared types and helpers for the APB register bank.
package apb_reg_pkg;

  typedef enum logic {IDLE, ACCESS} apb_state_e;

  localparam int WAIT_CNT_W = 4;

  // LSB position of register idx inside the flattened reg_q bus
  function automatic int unsigned reg_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/apb_slave_fsm.sv
// APB slave handshake: IDLE/ACCESS state, wait-state counter, completion and
// address-range decode. pready comes only from registered state.
module apb_slave_fsm
  import apb_reg_pkg::*;
#(
  parameter int NUM_REGS    = 3,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  output logic              pready,
  output logic              complete,
  output logic              access_err
);

  apb_state_e            state_q;
  logic [WAIT_CNT_W-1:0] cnt_q;

  // Setup loads the wait count; access counts down, then completes. Losing
  // psel mid-access drops back to IDLE without completing.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            state_q <= ACCESS;
            cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (penable) begin
            if (cnt_q != '0) cnt_q <= cnt_q - WAIT_CNT_W'(1);
            else             state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready     = (state_q == ACCESS) && (cnt_q == '0);
  assign complete   = pready && psel && penable;
  assign access_err = 32'(paddr) >= 32'(NUM_REGS);

endmodule

// File: rtl/apb_reg_bank.sv
// Parametrised APB register bank: NUM_REGS x DATA_W registers, wait states,
// out-of-range error, per-register write pulses.
// Optional byte strobes: define APB_REG_PSTRB_EN to add the pstrb port.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 3,
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
`ifdef APB_REG_PSTRB_EN
  input  logic [DATA_W/8-1:0]        pstrb,
`endif
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int NB = DATA_W / 8;

  logic                              complete, err, rd_strb_err, wr_en;
  logic [NB-1:0]                     strb_eff;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]               wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]                 rd_data;

  apb_slave_fsm #(
    .NUM_REGS    (NUM_REGS),
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .pclk       (pclk),
    .preset     (preset),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pready     (pready),
    .complete   (complete),
    .access_err (err)
  );

`ifdef APB_REG_PSTRB_EN
  // Reads must carry an all-zero strobe; anything else is an error response
  assign strb_eff    = pstrb;
  assign rd_strb_err = !pwrite && (pstrb != '0);
`else
  assign strb_eff    = '1;
  assign rd_strb_err = 1'b0;
`endif

  // An all-zero strobe write completes OKAY but touches nothing
  assign wr_en = complete && pwrite && !err && (strb_eff != '0);

  // Byte-lane merge into the addressed register and one-cycle update pulse
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (paddr == ADDR_W'(i))) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < NB; b++)
          if (strb_eff[b]) regs_d[i][b*8 +: 8] = pwdata[b*8 +: 8];
      end
    end
  end

  // Register array and pulses; reset overrides any same-cycle commit
  always_ff @(posedge pclk) begin
    if (preset) begin
      regs_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read mux, gated so prdata is zero outside a good read completion
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (paddr == ADDR_W'(i)) rd_data = regs_q[i];
  end

  assign prdata   = (pready && !pwrite && !err && !rd_strb_err) ? rd_data : '0;
  assign pslverr  = pready && (err || rd_strb_err);
  assign wr_pulse = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[reg_lsb(g, DATA_W) +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: three 8-bit banks with 0/2/3 wait states
// share the bus (separate psel); a 32-bit strobe bank is added with
// APB_REG_PSTRB_EN.
module tb_apb_reg_bank;

  logic        pclk = 1'b0;
  logic        preset, penable, pwrite;
  logic [3:0]  psel;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  logic [7:0]  rd0, rd2, rd3;
  logic        rdy0, rdy2, rdy3, err0, err2, err3;
  logic [23:0] rq0, rq2, rq3;
  logic [2:0]  wp0, wp2, wp3;

  always #5 pclk = ~pclk;

  apb_reg_bank #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(4), .WAIT_CYCLES(0)) u0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]),
`ifdef APB_REG_PSTRB_EN
    .pstrb(1'b1),
`endif
    .prdata(rd0), .pready(rdy0), .pslverr(err0), .reg_q(rq0), .wr_pulse(wp0));

  apb_reg_bank #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(4), .WAIT_CYCLES(2)) u2 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]),
`ifdef APB_REG_PSTRB_EN
    .pstrb(1'b1),
`endif
    .prdata(rd2), .pready(rdy2), .pslverr(err2), .reg_q(rq2), .wr_pulse(wp2));

  apb_reg_bank #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(4), .WAIT_CYCLES(3)) u3 (
    .pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]),
`ifdef APB_REG_PSTRB_EN
    .pstrb(1'b1),
`endif
    .prdata(rd3), .pready(rdy3), .pslverr(err3), .reg_q(rq3), .wr_pulse(wp3));

`ifdef APB_REG_PSTRB_EN
  logic [3:0]  pstrb;
  logic [31:0] rds;
  logic        rdys, errs;
  logic [95:0] rqs;
  logic [2:0]  wps;

  apb_reg_bank #(.DATA_W(32), .NUM_REGS(3), .ADDR_W(4), .WAIT_CYCLES(0)) us (
    .pclk(pclk), .preset(preset), .psel(psel[3]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(rds), .pready(rdys), .pslverr(errs), .reg_q(rqs), .wr_pulse(wps));
`endif

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic bus_idle();
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    bus_idle();
    step(); step();
    preset = 1'b0;
    tot_cnt++; if (rq0 !== 24'h0) $display("FAIL rst_reg_q got %h exp %h", rq0, 24'h0); else pass_cnt++;
    tot_cnt++; if (wp0 !== 3'b000) $display("FAIL rst_wr_pulse got %b exp %b", wp0, 3'b000); else pass_cnt++;
    tot_cnt++; if ({rdy0, err0, rd0} !== 10'h0) $display("FAIL rst_outputs got %h exp %h", {rdy0, err0, rd0}, 10'h0); else pass_cnt++;
  endtask

  task automatic test_write_read();
    psel[0] = 1'b1; pwrite = 1'b1; paddr = 4'd1; pwdata = 32'hA5;
    tot_cnt++; if (rdy0 !== 1'b0) $display("FAIL wr_setup_pready got %b exp %b", rdy0, 1'b0); else pass_cnt++;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdy0, err0} !== 2'b10) $display("FAIL wr_access_rdy_err got %b exp %b", {rdy0, err0}, 2'b10); else pass_cnt++;
    step();
    // read setup immediately after completion
    penable = 1'b0; pwrite = 1'b0; paddr = 4'd1; pwdata = '0;
    tot_cnt++; if (wp0 !== 3'b010) $display("FAIL wr_pulse got %b exp %b", wp0, 3'b010); else pass_cnt++;
    tot_cnt++; if (rq0 !== 24'h00A500) $display("FAIL wr_reg_q got %h exp %h", rq0, 24'h00A500); else pass_cnt++;
    step(); penable = 1'b1;
    tot_cnt++; if (wp0 !== 3'b000) $display("FAIL wr_pulse_clear got %b exp %b", wp0, 3'b000); else pass_cnt++;
    tot_cnt++; if ({rdy0, err0, rd0} !== {2'b10, 8'hA5}) $display("FAIL rd_data got %h exp %h", {rdy0, err0, rd0}, {2'b10, 8'hA5}); else pass_cnt++;
    step(); bus_idle();
  endtask

  task automatic test_wait_states();
    psel[1] = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h3C;
    step(); penable = 1'b1;
    tot_cnt++; if (rdy2 !== 1'b0) $display("FAIL ws_pready_1 got %b exp %b", rdy2, 1'b0); else pass_cnt++;
    step(); pwdata = 32'h11;
    tot_cnt++; if (rdy2 !== 1'b0) $display("FAIL ws_pready_2 got %b exp %b", rdy2, 1'b0); else pass_cnt++;
    step();
    tot_cnt++; if (rdy2 !== 1'b1) $display("FAIL ws_pready_3 got %b exp %b", rdy2, 1'b1); else pass_cnt++;
    tot_cnt++; if (rq2 !== 24'h0) $display("FAIL ws_reg_early got %h exp %h", rq2, 24'h0); else pass_cnt++;
    step(); bus_idle();
    tot_cnt++; if (rq2 !== 24'h000011) $display("FAIL ws_reg_q got %h exp %h", rq2, 24'h000011); else pass_cnt++;
    tot_cnt++; if (wp2 !== 3'b001) $display("FAIL ws_pulse got %b exp %b", wp2, 3'b001); else pass_cnt++;
  endtask

  task automatic test_addr_error();
    psel[0] = 1'b1; pwrite = 1'b1; paddr = 4'd5; pwdata = 32'hFF;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdy0, err0} !== 2'b11) $display("FAIL err_wr_resp got %b exp %b", {rdy0, err0}, 2'b11); else pass_cnt++;
    step(); penable = 1'b0; pwrite = 1'b0;
    tot_cnt++; if (wp0 !== 3'b000) $display("FAIL err_wr_pulse got %b exp %b", wp0, 3'b000); else pass_cnt++;
    tot_cnt++; if (rq0 !== 24'h00A500) $display("FAIL err_wr_reg_q got %h exp %h", rq0, 24'h00A500); else pass_cnt++;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdy0, err0, rd0} !== {2'b11, 8'h00}) $display("FAIL err_rd_resp got %h exp %h", {rdy0, err0, rd0}, {2'b11, 8'h00}); else pass_cnt++;
    step(); bus_idle();
  endtask

  task automatic test_back_to_back();
    psel[0] = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h01;
    step(); penable = 1'b1;
    step(); penable = 1'b0; paddr = 4'd1; pwdata = 32'h02;
    tot_cnt++; if (wp0 !== 3'b001) $display("FAIL b2b_pulse_0 got %b exp %b", wp0, 3'b001); else pass_cnt++;
    step(); penable = 1'b1;
    step(); penable = 1'b0; paddr = 4'd2; pwdata = 32'h03;
    tot_cnt++; if (wp0 !== 3'b010) $display("FAIL b2b_pulse_1 got %b exp %b", wp0, 3'b010); else pass_cnt++;
    step(); penable = 1'b1;
    step(); bus_idle();
    tot_cnt++; if (wp0 !== 3'b100) $display("FAIL b2b_pulse_2 got %b exp %b", wp0, 3'b100); else pass_cnt++;
    tot_cnt++; if (rq0 !== 24'h030201) $display("FAIL b2b_reg_q got %h exp %h", rq0, 24'h030201); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    // seed u3 so the reset has something to clear
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h5A;
    step(); penable = 1'b1;
    repeat (4) step();
    bus_idle();
    tot_cnt++; if (rq3 !== 24'h00005A) $display("FAIL rm_seed got %h exp %h", rq3, 24'h00005A); else pass_cnt++;
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 4'd2; pwdata = 32'h77;
    step(); penable = 1'b1;
    step(); preset = 1'b1;
    step(); preset = 1'b0; bus_idle();
    tot_cnt++; if ({rq3, wp3, rdy3} !== 28'h0) $display("FAIL rm_cleared got %h exp %h", {rq3, wp3, rdy3}, 28'h0); else pass_cnt++;
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 4'd2; pwdata = 32'h99;
    step(); penable = 1'b1;
    repeat (3) step();
    tot_cnt++; if ({rdy3, err3} !== 2'b10) $display("FAIL rm_next_resp got %b exp %b", {rdy3, err3}, 2'b10); else pass_cnt++;
    step(); bus_idle();
    tot_cnt++; if ({rq3, wp3} !== {24'h990000, 3'b100}) $display("FAIL rm_next_write got %h exp %h", {rq3, wp3}, {24'h990000, 3'b100}); else pass_cnt++;
  endtask

`ifdef APB_REG_PSTRB_EN
  task automatic test_strobe();
    psel[3] = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h11223344; pstrb = 4'hF;
    step(); penable = 1'b1;
    step(); penable = 1'b0; pwdata = 32'hAABBCCDD; pstrb = 4'b0101;
    tot_cnt++; if (rqs[31:0] !== 32'h11223344) $display("FAIL st_full got %h exp %h", rqs[31:0], 32'h11223344); else pass_cnt++;
    step(); penable = 1'b1;
    step(); penable = 1'b0; pwdata = 32'h55667788; pstrb = 4'b0000;
    tot_cnt++; if ({rqs[31:0], wps} !== {32'h11BB33DD, 3'b001}) $display("FAIL st_partial got %h exp %h", {rqs[31:0], wps}, {32'h11BB33DD, 3'b001}); else pass_cnt++;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdys, errs} !== 2'b10) $display("FAIL st_zero_resp got %b exp %b", {rdys, errs}, 2'b10); else pass_cnt++;
    step(); penable = 1'b0; pwrite = 1'b0; pstrb = 4'b0001;
    tot_cnt++; if ({rqs[31:0], wps} !== {32'h11BB33DD, 3'b000}) $display("FAIL st_zero_nochg got %h exp %h", {rqs[31:0], wps}, {32'h11BB33DD, 3'b000}); else pass_cnt++;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdys, errs, rds} !== {2'b11, 32'h0}) $display("FAIL st_rd_strb got %h exp %h", {rdys, errs, rds}, {2'b11, 32'h0}); else pass_cnt++;
    step(); penable = 1'b0; pstrb = 4'b0000;
    step(); penable = 1'b1;
    tot_cnt++; if ({rdys, errs, rds} !== {2'b10, 32'h11BB33DD}) $display("FAIL st_rd_ok got %h exp %h", {rdys, errs, rds}, {2'b10, 32'h11BB33DD}); else pass_cnt++;
    step(); bus_idle();
  endtask
`endif

  initial begin
`ifdef APB_REG_PSTRB_EN
    pstrb = '0;
`endif
    test_reset();
    test_write_read();
    test_wait_states();
    test_addr_error();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_REG_PSTRB_EN
    test_strobe();
`endif
    step();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
Parametrised APB slave register bank; next generation of the fixed three-register write block. Generalised to NUM_REGS registers of DATA_W bits, with full read/write, programmable wait states, error response on out-of-range index, and per-register write pulses. Sits behind the APB decoder (one psel per bank) and feeds payload/config registers to the datapath.

Parameters:
DATA_W, 8, register and pwdata/prdata width; must be a multiple of 8.
NUM_REGS, 3, number of registers; index 0..NUM_REGS-1.
ADDR_W, 4, paddr width, word index, not bytes; 2**ADDR_W >= NUM_REGS.
WAIT_CYCLES, 0, pready-low cycles inserted in each access phase (0..15).

Ports:
pclk  in  1  clock
preset  in  1  synchronous active-high reset
psel  in  1  bank select
penable  in  1  APB access phase
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register index
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte strobes; present only with APB_REG_PSTRB_EN
prdata  out  DATA_W  read data
pready  out  1  transfer complete
pslverr  out  1  error response
reg_q  out  NUM_REGS*DATA_W  register contents, flattened; reg i at [i*DATA_W +: DATA_W]
wr_pulse  out  NUM_REGS  one-cycle pulse per register update

Behaviour:
- One clock, pclk. Reset is synchronous and active-high (preset); all state updates on posedge pclk.
- Reset values:
  - all registers 0, so reg_q = 0
  - wr_pulse = 0
  - FSM = IDLE, wait counter = 0
  - pready, pslverr and prdata all 0 while in IDLE.
- FSM states and transitions:
  - IDLE: on psel && !penable (setup), go to ACCESS and load cnt = WAIT_CYCLES.
  - ACCESS, wait phase: while psel && penable && cnt != 0, decrement cnt.
  - ACCESS, completion: pready = (cnt == 0), decoded from registered state only, never from inputs. The cycle with psel && penable && pready completes the transfer; next state is IDLE.
  - ACCESS, abort: if psel deasserts (protocol violation), go to IDLE with no commit and no pulse.
- Back-to-back transfers: the setup of the next transfer arrives in the cycle after completion, when the FSM is already in IDLE; no dead cycle.
- Latency: access phase lasts WAIT_CYCLES+1 cycles, so a full transfer is WAIT_CYCLES+2 cycles.
- Address check: err = (paddr >= NUM_REGS). pslverr = pready && err; 0 otherwise.
- Write commit at completion edge, when pwrite && !err:
  - reg[paddr] <= pwdata.
  - wr_pulse[paddr] = 1 for exactly the following cycle.
  - Erroring writes change no register and give no pulse.
- Read: prdata = reg[paddr] when pready && !pwrite && !err; 0 otherwise, combinational from registers. Reads have no side effects.
- Reset mid-transfer: preset wins over any commit in the same cycle. Transfer aborted, FSM to IDLE, wr_pulse cleared.
- Inputs sampled only during the completing cycle; paddr/pwdata changes during wait cycles are ignored until that cycle.

Optional Feature:
APB_REG_PSTRB_EN
- Defined:
  - pstrb port exists; on commit only byte lanes with pstrb[b] = 1 update.
  - pstrb all-zero write: no register change, no wr_pulse, still completes OKAY.
  - Read with pstrb != 0: pslverr = 1, prdata = 0 (APB4 rule).
- Undefined: pstrb port absent; every write updates the full word.

Decomposition:
- Package apb_reg_pkg:
  - state enum apb_state_e {IDLE, ACCESS}
  - localparam WAIT_CNT_W = 4
  - function for the flattened slice index.
- Sub-module apb_slave_fsm: owns state and wait counter; outputs pready, complete and access_err.
- apb_reg_bank instantiates apb_slave_fsm and holds the register array, strobe merge and read mux.

Test Plan:
- Reset: NUM_REGS=3, WAIT_CYCLES=0; write 0xA5 to index 1 -> pready high in the first access cycle, pslverr 0, wr_pulse = 3'b010 for one cycle, reg_q[15:8] = 0xA5. Then read index 1 -> prdata = 0xA5.
- WAIT_CYCLES=2: write 0x3C to index 0 -> pready low for 2 access cycles, high on the 3rd. Register unchanged until the completion edge; pwdata changed mid-wait to 0x11 -> register holds 0x11.
- Write 0xFF to paddr = 5 with NUM_REGS=3 -> pslverr = 1 with pready, no register change, wr_pulse = 0. Read paddr = 5 -> prdata = 0, pslverr = 1.
- Back-to-back writes to indices 0, 1, 2 (0x01, 0x02, 0x03) with no idle cycles -> each completes, wr_pulse walks 001, 010, 100, and reg_q = 0x030201.
- preset asserted in the wait cycle of a write with WAIT_CYCLES=3 -> all registers 0, FSM IDLE, no wr_pulse. The next write succeeds normally.
- APB_REG_PSTRB_EN, DATA_W=32: reg 0 = 0x11223344; write 0xAABBCCDD with pstrb = 4'b0101 -> reg 0 = 0x11BB33DD. Write with pstrb = 0 -> unchanged, no pulse. Read with pstrb = 1 -> pslverr = 1.
